// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: function codes and FSM encoding.
// Imported by the arbiter, its ALU and the bench.
package alu_arbiter_pkg;

  localparam logic [4:0] FN_SHR = 5'b00000;
  localparam logic [4:0] FN_ADD = 5'b00010;
  localparam logic [4:0] FN_SUB = 5'b00011;
  localparam logic [4:0] FN_AND = 5'b01000;
  localparam logic [4:0] FN_OR  = 5'b01100;
  localparam logic [4:0] FN_SHL = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 4-bit combinational ALU; unknown function codes yield zero data with err_o set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [4:0] f_i,
  output logic [3:0] y_o,
  output logic       err_o
);

  always_comb begin
    y_o   = 4'd0;
    err_o = 1'b0;
    case (f_i)
      FN_ADD:  y_o = a_i + b_i;
      FN_SUB:  y_o = a_i - b_i;
      FN_AND:  y_o = a_i & b_i;
      FN_OR:   y_o = a_i | b_i;
      FN_SHR:  y_o = {1'b0, a_i[3:1]};
      FN_SHL:  y_o = {a_i[2:0], 1'b0};
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU: grant in IDLE, compute in EXEC, hold the result in RESP
// until the consumer takes it. Round-robin or fixed priority selected by FIXED_PRI.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [4:0] req0_f,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [4:0] req1_f,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);

  localparam bit ROUND_ROBIN = (FIXED_PRI == 0);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [4:0] f_q, f_d;
  logic       id_q, id_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d;
  logic       rid_q, rid_d;

  logic       pick1;
  logic       gnt0, gnt1;
  logic [3:0] alu_y;
  logic       alu_err;

  alu_arbiter_alu u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .f_i   (f_q),
    .y_o   (alu_y),
    .err_o (alu_err)
  );

  // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
  assign pick1 = req1_valid && (!req0_valid || (ROUND_ROBIN && ptr_q));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    rid_d   = rid_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt1    = pick1;
          gnt0    = !pick1;
          a_d     = pick1 ? req1_a : req0_a;
          b_d     = pick1 ? req1_b : req0_b;
          f_d     = pick1 ? req1_f : req0_f;
          id_d    = pick1;
          state_d = EXEC;
          if (ROUND_ROBIN) begin
            ptr_d = !pick1;
          end
        end
      end
      EXEC: begin
        data_d  = alu_y;
        err_d   = alu_err;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is qualified by rst_n so no handshake can complete while reset is applied.
  assign req0_ready = rst_n && gnt0;
  assign req1_ready = rst_n && gnt1;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rid_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      f_q     <= 5'd0;
      id_q    <= 1'b0;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRI, default 0, 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4  unsigned operands.
REQ-007 req0_f / req1_f  input  5  ALU function code.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester that issued the result.
REQ-011 rsp_data  output  4  result value.
REQ-012 rsp_err  output  1  function code was not a legal code.

Function
REQ-013 Function codes SHALL be: ADD 00010 (a+b mod 16), SUB 00011 (a-b mod 16), AND 01000, OR 01100, SHR 00000 ({0,a[3:1]}), SHL 10000 ({a[2:0],0}); b ignored for shifts.
REQ-014 Any other code SHALL produce rsp_data 0000 and rsp_err 1; legal codes SHALL produce rsp_err 0.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, latch its a/b/f and id, go to EXEC; else stay.
REQ-017 reqN_ready SHALL be 0 in EXEC and RESP, and never asserted for both requesters in one cycle.
REQ-018 Round-robin: a priority pointer, reset to requester 0, SHALL point to the requester that was not granted after each grant; if only one is valid, it is granted regardless of pointer.
REQ-019 With FIXED_PRI=1, requester 0 SHALL win every simultaneous request; pointer is unused.
REQ-020 EXEC: the shared ALU evaluates the latched operands; result, error flag and id registered at the end of the cycle; go to RESP.
REQ-021 RESP: rsp_valid=1; rsp_data/rsp_id/rsp_err held stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-022 Latency: accept at edge N, rsp_valid high from cycle N+2; max throughput one operation per 3 cycles.
REQ-023 New requests arriving during EXEC/RESP SHALL be left pending (ready low), not dropped; requesters hold valid and operands until ready.
REQ-024 rsp_valid SHALL never drop without a handshake.

Reset
REQ-025 rst_n low at a rising edge: state IDLE, pointer to requester 0, rsp_valid 0, rsp_data 0000, rsp_id 0, rsp_err 0, latched operands 0.
REQ-026 Reset in EXEC or RESP SHALL abandon the operation; no response is issued for it.
REQ-027 req0_ready and req1_ready SHALL be 0 while rst_n is low.

Structure
REQ-028 The six function-code constants and the FSM state encoding SHALL live in a shared package used by this block, the ALU and benches.
REQ-029 The arithmetic SHALL be done by exactly one instance of the existing ALU module; no second datapath in the block.
REQ-030 Arbitration (pointer + grant logic) MAY be a sub-module named rr_arb2.

Verification
REQ-031 req0: a=7, b=5, f=00010, rsp_ready=1 -> ready at cycle N, rsp_valid at N+2, rsp_data=12, rsp_id=0, rsp_err=0.
REQ-032 req1: a=3, b=5, f=00011 -> rsp_data=1110, rsp_id=1; a=1001, f=10000 -> 0010; a=1001, f=00000 -> 0100.
REQ-033 Both valid continuously after reset, FIXED_PRI=0 -> grants alternate 0,1,0,1; with FIXED_PRI=1 -> requester 0 every time.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id constant, both readys 0; release -> IDLE next cycle.
REQ-035 f=00001, a=15, b=15 -> rsp_data=0000, rsp_err=1.
REQ-036 rst_n low during EXEC -> next cycle rsp_valid=0, state IDLE, pointer 0, no response for aborted op; pending request then served normally.
